core_alu_exec: RTL and testbench
================================

// Module: core_alu_exec
// PURPOSE
// - Execution end of the ALU control interface: consumes one-hot core_alu_ctl::control_type words from the
//   decoder/sequencer, computes the 8-bit result and N/V/Z/C flags, and returns them registered.
// - Sits between the instruction sequencer and the register file/P-register writeback in the 2A03 core.
// - Valid/ready on both sides; 2-entry skid buffer lets the sequencer stream one op per clock under backpressure.
// PARAMETERS
// - CHECK_ONEHOT  1  1: malformed control words are flagged and executed as nop; 0: no check (o_illegal tied 0)
// PORTS
// - clk        in   1   core clock
// - rst_n      in   1   asynchronous active-low reset
// - i_valid    in   1   request valid
// - o_ready    out  1   request accepted when i_valid & o_ready
// - i_control  in   16  core_alu_ctl::control_type, one-hot or zero (nop)
// - i_lhs      in   8   left operand (accumulator/index side)
// - i_rhs      in   8   right operand (memory/immediate side; shift/inc/dec source)
// - i_flags    in   4   incoming {N,V,Z,C}
// - o_valid    out  1   result valid
// - i_ready    in   1   result consumed when o_valid & i_ready
// - o_result   out  8   result byte
// - o_flags    out  4   outgoing {N,V,Z,C}
// - o_illegal  out  1   accompanies result: request's control word was not one-hot/zero, or bit 0 set
// BEHAVIOUR
// - Reset (async): o_valid=0, o_ready=1, o_result=0, o_flags=0, o_illegal=0, skid empty.
// - Latency: accepted request appears on outputs the next clock when output stage free; throughput 1/clk.
// - o_ready = skid entry empty (registered). Output stage loads from skid if occupied, else from input.
// - Output held stable while o_valid & !i_ready. Accept while out stalled -> into skid; then o_ready=0.
// - Simultaneous accept and consume: in-order, no bubble, no loss; skid drains before new input.
// - Unlisted flags pass through from i_flags. N,Z always from result unless stated. C=carry out bit 8.
//   nop: r=lhs, all flags pass.   adc: r=lhs+rhs+C; C,V(signed overflow),N,Z.
//   sbc: r=lhs+~rhs+C; C=no-borrow, V, N, Z.   cmp: d=lhs-rhs; r=lhs; C=(lhs>=rhs) unsigned, N,Z from d.
//   bit: r=lhs; Z=((lhs&rhs)==0), N=rhs[7], V=rhs[6].   and/or/xor: r=lhs op rhs; N,Z.
//   rol: r={rhs[6:0],C}, C=rhs[7].  ror: r={C,rhs[7:1]}, C=rhs[0].  asl: {rhs[6:0],0}, C=rhs[7].
//   lsr: {0,rhs[7:1]}, C=rhs[0] (N=0).  inc: rhs+1 mod 256.  dec: rhs-1 mod 256 (inc/dec: N,Z only).
//   txl: r=lhs; txr: r=rhs; N,Z only.
// - Illegal (CHECK_ONEHOT=1): >1 bit set or bit 0 set -> executed as nop, o_illegal=1 with that result.
// - Arithmetic is 9-bit internally; no decimal mode (2A03).
// - Reset mid-stream: all in-flight entries discarded, no partial output.
// STRUCTURE
// - core_alu_ctl package gains flag index constants (flag_n=3, flag_v=2, flag_z=1, flag_c=0) and
//   typedef logic[3:0] flags_type; control bit positions reused, never redefined here.
// - One combinational sub-module core_alu_ops (control, lhs, rhs, flags -> result, flags, illegal);
//   core_alu_exec holds only the skid buffer and output register around it.
// TESTING
// - adc lhs=0x50 rhs=0x50 C=0 -> r=0xA0, N=1 V=1 Z=0 C=0; adc 0xFF+0x01 C=0 -> r=0x00, Z=1 C=1 V=0.
// - sbc lhs=0x50 rhs=0xB0 C=1 -> r=0xA0, V=1 C=0; cmp 0x10 vs 0x10 -> r=0x10, Z=1 C=1 N=0, V passed.
// - bit lhs=0x0F rhs=0xC0 -> Z=1 N=1 V=1, r=0x0F; ror rhs=0x01 C=1 -> r=0x80 C=1 N=1; dec 0x00 -> 0xFF N=1.
// - control=0x0006 (adc|sbc) and control=0x0001 -> r=lhs, flags=i_flags, o_illegal=1.
// - stream 8 ops with i_ready low cycles 2-4 -> o_ready drops after 2 queued, outputs in order, none lost/dup.
// - rst_n low with skid full and o_valid=1 -> o_valid=0, o_ready=1 immediately; first op after reset correct.

Source files
------------

// File: rtl/core_alu_ctl.sv
// ALU control word layout, flag indices and the registered response record
// shared by the ALU execution stage and its sequencer.
package core_alu_ctl;

  // One-hot control word; all-zero means nop, bit 0 is reserved and never legal.
  typedef logic [15:0] control_type;

  localparam int ctl_rsvd = 0;
  localparam int ctl_adc  = 1;
  localparam int ctl_sbc  = 2;
  localparam int ctl_cmp  = 3;
  localparam int ctl_bit  = 4;
  localparam int ctl_and  = 5;
  localparam int ctl_or   = 6;
  localparam int ctl_xor  = 7;
  localparam int ctl_rol  = 8;
  localparam int ctl_ror  = 9;
  localparam int ctl_asl  = 10;
  localparam int ctl_lsr  = 11;
  localparam int ctl_inc  = 12;
  localparam int ctl_dec  = 13;
  localparam int ctl_txl  = 14;
  localparam int ctl_txr  = 15;

  // Flag nibble ordering {N,V,Z,C}.
  localparam int flag_n = 3;
  localparam int flag_v = 2;
  localparam int flag_z = 1;
  localparam int flag_c = 0;
  typedef logic [3:0] flags_type;

  typedef struct packed {
    logic [7:0] result;
    flags_type  flags;
    logic       illegal;
  } alu_resp_type;

  // More than one bit set, or the reserved bit set.
  function automatic logic is_malformed(control_type c);
    return c[ctl_rsvd] | (|(c & (c - 16'd1)));
  endfunction

endpackage

// File: rtl/core_alu_exec_if.sv
// Request/response bundle between the sequencer (master) and the ALU execution stage (slave).
interface core_alu_exec_if;
  import core_alu_ctl::*;

  logic        i_valid;
  logic        o_ready;
  control_type i_control;
  logic [7:0]  i_lhs;
  logic [7:0]  i_rhs;
  flags_type   i_flags;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_result;
  flags_type   o_flags;
  logic        o_illegal;

  modport slave (
    input  i_valid, i_control, i_lhs, i_rhs, i_flags, i_ready,
    output o_ready, o_valid, o_result, o_flags, o_illegal
  );

  modport master (
    output i_valid, i_control, i_lhs, i_rhs, i_flags, i_ready,
    input  o_ready, o_valid, o_result, o_flags, o_illegal
  );
endinterface

// File: rtl/core_alu_ops.sv
// Purely combinational 2A03 ALU: one-hot control word in, result byte and flags out.
// No decimal mode; arithmetic is carried out 9 bits wide.
module core_alu_ops
  import core_alu_ctl::*;
#(
  parameter bit CHECK_ONEHOT = 1'b1
) (
  input  control_type i_control,
  input  logic [7:0]  i_lhs,
  input  logic [7:0]  i_rhs,
  input  flags_type   i_flags,
  output logic [7:0]  o_result,
  output flags_type   o_flags,
  output logic        o_illegal
);

  logic [8:0] w_sum_adc;
  logic [8:0] w_sum_sbc;
  logic [8:0] w_diff_cmp;
  logic       w_illegal;
  logic       w_set_nz;

  assign w_illegal  = CHECK_ONEHOT ? is_malformed(i_control) : 1'b0;
  assign w_sum_adc  = {1'b0, i_lhs} + {1'b0, i_rhs} + {8'd0, i_flags[flag_c]};
  assign w_sum_sbc  = {1'b0, i_lhs} + {1'b0, ~i_rhs} + {8'd0, i_flags[flag_c]};
  assign w_diff_cmp = {1'b0, i_lhs} + {1'b0, ~i_rhs} + 9'd1;
  assign o_illegal  = w_illegal;

  // Operation select; malformed words fall through as nop (r=lhs, flags pass).
  always_comb begin
    o_result = i_lhs;
    o_flags  = i_flags;
    w_set_nz = 1'b0;
    if (!w_illegal) begin
      if (i_control[ctl_adc]) begin
        o_result        = w_sum_adc[7:0];
        o_flags[flag_c] = w_sum_adc[8];
        o_flags[flag_v] = (i_lhs[7] == i_rhs[7]) && (w_sum_adc[7] != i_lhs[7]);
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_sbc]) begin
        o_result        = w_sum_sbc[7:0];
        o_flags[flag_c] = w_sum_sbc[8];
        o_flags[flag_v] = (i_lhs[7] != i_rhs[7]) && (w_sum_sbc[7] != i_lhs[7]);
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_cmp]) begin
        o_flags[flag_c] = w_diff_cmp[8];
        o_flags[flag_n] = w_diff_cmp[7];
        o_flags[flag_z] = (w_diff_cmp[7:0] == 8'd0);
      end else if (i_control[ctl_bit]) begin
        o_flags[flag_z] = ((i_lhs & i_rhs) == 8'd0);
        o_flags[flag_n] = i_rhs[7];
        o_flags[flag_v] = i_rhs[6];
      end else if (i_control[ctl_and]) begin
        o_result = i_lhs & i_rhs;
        w_set_nz = 1'b1;
      end else if (i_control[ctl_or]) begin
        o_result = i_lhs | i_rhs;
        w_set_nz = 1'b1;
      end else if (i_control[ctl_xor]) begin
        o_result = i_lhs ^ i_rhs;
        w_set_nz = 1'b1;
      end else if (i_control[ctl_rol]) begin
        o_result        = {i_rhs[6:0], i_flags[flag_c]};
        o_flags[flag_c] = i_rhs[7];
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_ror]) begin
        o_result        = {i_flags[flag_c], i_rhs[7:1]};
        o_flags[flag_c] = i_rhs[0];
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_asl]) begin
        o_result        = {i_rhs[6:0], 1'b0};
        o_flags[flag_c] = i_rhs[7];
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_lsr]) begin
        o_result        = {1'b0, i_rhs[7:1]};
        o_flags[flag_c] = i_rhs[0];
        w_set_nz        = 1'b1;
      end else if (i_control[ctl_inc]) begin
        o_result = i_rhs + 8'd1;
        w_set_nz = 1'b1;
      end else if (i_control[ctl_dec]) begin
        o_result = i_rhs - 8'd1;
        w_set_nz = 1'b1;
      end else if (i_control[ctl_txl]) begin
        w_set_nz = 1'b1;
      end else if (i_control[ctl_txr]) begin
        o_result = i_rhs;
        w_set_nz = 1'b1;
      end
    end
    if (w_set_nz) begin
      o_flags[flag_n] = o_result[7];
      o_flags[flag_z] = (o_result == 8'd0);
    end
  end

endmodule

// File: rtl/core_alu_exec.sv
// ALU execution stage: combinational ALU feeding a registered output stage
// backed by one skid entry, so the sequencer can issue one op per clock and
// a single stalled cycle never loses an accepted request.
module core_alu_exec
  import core_alu_ctl::*;
#(
  parameter bit CHECK_ONEHOT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  core_alu_exec_if.slave  bus
);

  logic [7:0]   w_new_result;
  flags_type    w_new_flags;
  logic         w_new_illegal;
  alu_resp_type w_new;
  logic         w_accept;
  logic         w_out_free;

  alu_resp_type r_out;
  logic         r_out_valid;
  alu_resp_type r_skid;
  logic         r_skid_valid;

  core_alu_ops #(.CHECK_ONEHOT(CHECK_ONEHOT)) u_ops (
    .i_control (bus.i_control),
    .i_lhs     (bus.i_lhs),
    .i_rhs     (bus.i_rhs),
    .i_flags   (bus.i_flags),
    .o_result  (w_new_result),
    .o_flags   (w_new_flags),
    .o_illegal (w_new_illegal)
  );

  assign w_new      = '{result: w_new_result, flags: w_new_flags, illegal: w_new_illegal};
  assign w_accept   = bus.i_valid & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | bus.i_ready;

  assign bus.o_ready   = ~r_skid_valid;
  assign bus.o_valid   = r_out_valid;
  assign bus.o_result  = r_out.result;
  assign bus.o_flags   = r_out.flags;
  assign bus.o_illegal = r_out.illegal;

  // Output stage: refill from the skid entry first so order is preserved, else from the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out       <= r_skid;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out       <= w_new;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: catches a request accepted while the output is stalled; drains whenever the output moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else if (w_out_free) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_new;
    end
  end

endmodule

// File: tb/tb_core_alu_exec.sv
// Bench for core_alu_exec: directed vectors, illegal words, backpressured and
// random streams against an arithmetic reference model, and reset mid-stream.
module tb_core_alu_exec;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  core_alu_exec_if bus();

  core_alu_exec #(.CHECK_ONEHOT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic int sx(logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  // Reference model: returns {result, {N,V,Z,C}, illegal} from plain integer arithmetic.
  function automatic logic [12:0] ref_alu(logic [15:0] ctl, logic [7:0] l, logic [7:0] r, logic [3:0] f);
    int li, ri, c, t, sv;
    logic [7:0] res;
    logic [3:0] fo;
    logic nz, ill;
    li = int'(l); ri = int'(r); c = int'(f[0]);
    res = l; fo = f; nz = 1'b0;
    ill = ctl[0] || ($countones(ctl) > 1);
    if (!ill) begin
      case (ctl)
        16'h0002: begin t = li + ri + c; res = 8'(t); fo[0] = (t > 255);
                        sv = sx(l) + sx(r) + c; fo[2] = (sv > 127 || sv < -128); nz = 1'b1; end
        16'h0004: begin t = li - ri - (1 - c); res = 8'(t); fo[0] = (t >= 0);
                        sv = sx(l) - sx(r) - (1 - c); fo[2] = (sv > 127 || sv < -128); nz = 1'b1; end
        16'h0008: begin t = li - ri; fo[0] = (li >= ri); fo[3] = (8'(t) >= 8'd128); fo[1] = (t == 0); end
        16'h0010: begin fo[1] = ((l & r) == 8'd0); fo[3] = (ri >= 128); fo[2] = ((ri % 128) >= 64); end
        16'h0020: begin res = l & r; nz = 1'b1; end
        16'h0040: begin res = l | r; nz = 1'b1; end
        16'h0080: begin res = l ^ r; nz = 1'b1; end
        16'h0100: begin res = 8'(ri * 2 + c);   fo[0] = (ri >= 128); nz = 1'b1; end
        16'h0200: begin res = 8'(ri / 2 + c * 128); fo[0] = (ri % 2 == 1); nz = 1'b1; end
        16'h0400: begin res = 8'(ri * 2);       fo[0] = (ri >= 128); nz = 1'b1; end
        16'h0800: begin res = 8'(ri / 2);       fo[0] = (ri % 2 == 1); nz = 1'b1; end
        16'h1000: begin res = 8'(ri + 1);   nz = 1'b1; end
        16'h2000: begin res = 8'(ri + 255); nz = 1'b1; end
        16'h4000: begin res = l; nz = 1'b1; end
        16'h8000: begin res = r; nz = 1'b1; end
        default: ;
      endcase
    end
    if (nz) begin
      fo[3] = (res >= 8'd128);
      fo[1] = (res == 8'd0);
    end
    return {res, fo, ill};
  endfunction

  task automatic gen_op(output logic [15:0] ctl, output logic [7:0] l, output logic [7:0] r, output logic [3:0] f);
    int k;
    k = $urandom_range(0, 17);
    if (k < 16)       ctl = 16'd1 << k;
    else if (k == 16) ctl = 16'd0;
    else              ctl = 16'($urandom);
    l = 8'($urandom);
    r = 8'($urandom);
    f = 4'($urandom);
  endtask

  // Single op with the output free; returns what the output register shows next cycle.
  task automatic do_op(input logic [15:0] ctl, input logic [7:0] l, input logic [7:0] r, input logic [3:0] f,
                       output logic v, output logic [12:0] got);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_control = ctl; bus.i_lhs = l; bus.i_rhs = r; bus.i_flags = f;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    v   = bus.o_valid;
    got = {bus.o_result, bus.o_flags, bus.o_illegal};
  endtask

  task automatic drain();
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_control = '0;
    bus.i_lhs = '0; bus.i_rhs = '0; bus.i_flags = '0;
    #12;
    tests_run++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_handshake: got valid/ready=%b, need 01", {bus.o_valid, bus.o_ready});
    end
    tests_run++;
    if ({bus.o_result, bus.o_flags, bus.o_illegal} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, need 0000", {bus.o_result, bus.o_flags, bus.o_illegal});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [15:0] ctl;
    logic [7:0]  l;
    logic [7:0]  r;
    logic [3:0]  f;
    logic [12:0] exp;
  } vec_t;

  task automatic run_vectors(input vec_t vecs[$]);
    logic v;
    logic [12:0] got;
    foreach (vecs[i]) begin
      do_op(vecs[i].ctl, vecs[i].l, vecs[i].r, vecs[i].f, v, got);
      tests_run++;
      if ({v, got} !== {1'b1, vecs[i].exp}) begin
        tests_failed++;
        $display("FAIL %s: got valid=%b r=%h f=%b ill=%b, need valid=1 r=%h f=%b ill=%b",
                 vecs[i].name, v, got[12:5], got[4:1], got[0],
                 vecs[i].exp[12:5], vecs[i].exp[4:1], vecs[i].exp[0]);
      end
    end
  endtask

  task automatic test_directed();
    vec_t q[$];
    q.push_back('{"adc_overflow",  16'h0002, 8'h50, 8'h50, 4'b0000, {8'hA0, 4'b1100, 1'b0}});
    q.push_back('{"adc_wrap",      16'h0002, 8'hFF, 8'h01, 4'b0000, {8'h00, 4'b0011, 1'b0}});
    q.push_back('{"sbc_overflow",  16'h0004, 8'h50, 8'hB0, 4'b0001, {8'hA0, 4'b1100, 1'b0}});
    q.push_back('{"cmp_equal",     16'h0008, 8'h10, 8'h10, 4'b0100, {8'h10, 4'b0111, 1'b0}});
    q.push_back('{"bit_test",      16'h0010, 8'h0F, 8'hC0, 4'b0000, {8'h0F, 4'b1110, 1'b0}});
    q.push_back('{"ror_carry_in",  16'h0200, 8'h00, 8'h01, 4'b0001, {8'h80, 4'b1001, 1'b0}});
    q.push_back('{"dec_wrap",      16'h2000, 8'h00, 8'h00, 4'b0000, {8'hFF, 4'b1000, 1'b0}});
    q.push_back('{"lsr_n_clear",   16'h0800, 8'h00, 8'hFF, 4'b1000, {8'h7F, 4'b0001, 1'b0}});
    run_vectors(q);
  endtask

  task automatic test_illegal();
    vec_t q[$];
    q.push_back('{"illegal_adc_sbc", 16'h0006, 8'h33, 8'h77, 4'b1010, {8'h33, 4'b1010, 1'b1}});
    q.push_back('{"illegal_bit0",    16'h0001, 8'h81, 8'h00, 4'b0101, {8'h81, 4'b0101, 1'b1}});
    q.push_back('{"nop_zero",        16'h0000, 8'h00, 8'h12, 4'b1111, {8'h00, 4'b1111, 1'b0}});
    run_vectors(q);
  endtask

  // Cycle-driven stream; occupancy model says o_ready = (fewer than 2 in flight), o_valid = (any in flight).
  task automatic test_stream(input string name, input int n_ops, input bit rnd);
    logic [12:0] exp_q[$];
    logic [12:0] exp;
    logic [15:0] c_ctl;
    logic [7:0]  c_l, c_r;
    logic [3:0]  c_f;
    int sent, cyc, stalls;
    sent = 0; cyc = 0; stalls = 0;
    drain();
    gen_op(c_ctl, c_l, c_r, c_f);
    while ((sent < n_ops || exp_q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      bus.i_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc <= 4);
      bus.i_valid = (sent < n_ops) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.i_control = c_ctl; bus.i_lhs = c_l; bus.i_rhs = c_r; bus.i_flags = c_f;
      tests_run++;
      if ({bus.o_valid, bus.o_ready} !== {exp_q.size() > 0, exp_q.size() < 2}) begin
        tests_failed++;
        $display("FAIL %s_handshake cyc%0d: got valid/ready=%b%b, need %b%b", name, cyc,
                 bus.o_valid, bus.o_ready, exp_q.size() > 0, exp_q.size() < 2);
      end
      if (!bus.o_ready) stalls++;
      if (bus.o_valid && bus.i_ready && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tests_run++;
        if ({bus.o_result, bus.o_flags, bus.o_illegal} !== exp) begin
          tests_failed++;
          $display("FAIL %s_data cyc%0d: got r=%h f=%b ill=%b, need r=%h f=%b ill=%b", name, cyc,
                   bus.o_result, bus.o_flags, bus.o_illegal, exp[12:5], exp[4:1], exp[0]);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(ref_alu(c_ctl, c_l, c_r, c_f));
        sent++;
        gen_op(c_ctl, c_l, c_r, c_f);
      end
      @(posedge clk);
      cyc++;
    end
    #1 bus.i_valid = 1'b0;
    tests_run++;
    if (sent != n_ops || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_complete: got sent=%0d pending=%0d, need sent=%0d pending=0", name, sent, exp_q.size(), n_ops);
    end
    if (!rnd) begin
      tests_run++;
      if (stalls == 0) begin
        tests_failed++;
        $display("FAIL %s_backpressure: got 0 cycles with o_ready low, need at least 1", name);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic v;
    logic [12:0] got;
    drain();
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_valid = 1'b1;
    bus.i_control = 16'h0020; bus.i_lhs = 8'hF0; bus.i_rhs = 8'h3C; bus.i_flags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    tests_run++;
    if ({bus.o_valid, bus.o_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midreset_full: got valid/ready=%b%b, need 10", bus.o_valid, bus.o_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.o_valid, bus.o_ready, bus.o_result, bus.o_flags, bus.o_illegal} !== 15'b01_00000000_0000_0) begin
      tests_failed++;
      $display("FAIL midreset_clear: got valid=%b ready=%b r=%h f=%b, need valid=0 ready=1 r=00 f=0000",
               bus.o_valid, bus.o_ready, bus.o_result, bus.o_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0002, 8'h01, 8'h02, 4'b0000, v, got);
    tests_run++;
    if ({v, got} !== {1'b1, 8'h03, 4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_first_op: got valid=%b r=%h f=%b, need valid=1 r=03 f=0000", v, got[12:5], got[4:1]);
    end
    @(negedge clk);
    tests_run++;
    if (bus.o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_stale: got o_valid=%b, need 0", bus.o_valid);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_illegal();
    test_stream("back_to_back", 8, 1'b0);
    test_stream("random", 300, 1'b1);
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
